// File: rtl/data_mem_stall.sv
// Multi-cycle data memory with wait states, byte-enable writes and err pulses.
// Optional DATA_MEM_CLEAR_EN: sweep the array to zero after every reset.
module data_mem_stall #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic [DATA_W-1:0]   read_data,
    output logic                ready,
    output logic                busy,
    output logic                err
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DATA_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_rdata;
    logic [NB-1:0]     r_be;
    logic              r_wr;
    logic              r_rd;
    logic              r_bad;
    logic              r_both_err;
    logic              w_req;
    logic              w_both;
    logic              w_cap;
    logic              w_misal;
    logic              w_oor;
`ifdef DATA_MEM_CLEAR_EN
    logic [IW-1:0]     r_clr;
`endif

    assign w_req   = mem_read ^ mem_write;
    assign w_both  = (r_state == S_IDLE) && mem_read && mem_write;
    assign w_cap   = (r_state == S_IDLE) && w_req;
    assign w_misal = |adr[1:0];
    assign w_oor   = {2'b00, adr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DATA_MEM_CLEAR_EN
            r_state <= S_CLEAR;
`else
            r_state <= S_IDLE;
`endif
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT: if (r_cnt <= 4'd1) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
`ifdef DATA_MEM_CLEAR_EN
            S_CLEAR: if (r_clr == IW'(DEPTH - 1)) w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Errors are decided at capture; DONE just swaps ready for err.
    always_comb begin
        ready   = 1'b0;
        busy    = 1'b0;
        err     = r_both_err;
        w_rdata = r_hold;
        unique case (r_state)
            S_WAIT: busy = 1'b1;
            S_DONE: begin
                if (r_bad) begin
                    err     = 1'b1;
                    w_rdata = '0;
                end else begin
                    ready = 1'b1;
                    if (r_rd) w_rdata = r_mem[r_idx];
                end
            end
`ifdef DATA_MEM_CLEAR_EN
            S_CLEAR: busy = 1'b1;
`endif
            default: ;
        endcase
    end

    assign read_data = w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_bad      <= 1'b0;
            r_both_err <= 1'b0;
            r_hold     <= '0;
`ifdef DATA_MEM_CLEAR_EN
            r_clr      <= '0;
`endif
        end else begin
            r_both_err <= w_both;
            r_hold     <= w_both ? '0 : w_rdata;
            if (w_cap) begin
                r_idx   <= adr[IW+1:2];
                r_wdata <= write_data;
                r_be    <= byte_en;
                r_wr    <= mem_write;
                r_rd    <= mem_read;
                r_bad   <= w_misal || w_oor;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
`ifdef DATA_MEM_CLEAR_EN
            if (r_state == S_CLEAR) r_clr <= r_clr + IW'(1);
`endif
        end
    end

    // The write commits in the DONE cycle, so a visible ready implies it landed.
    always_ff @(posedge clk) begin
        if (r_state == S_DONE && r_wr && !r_bad) begin
            for (int b = 0; b < NB; b++) begin
                if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
`ifdef DATA_MEM_CLEAR_EN
        if (!rst && r_state == S_CLEAR) r_mem[r_clr] <= '0;
`endif
    end

endmodule

// File: tb/tb_data_mem_stall.sv
// Scoreboard bench for data_mem_stall: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_stall;
    localparam int DEPTH = 16;
    localparam int WA    = 2;
    localparam int WB    = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_adr, a_wd, a_rdata;
    logic [3:0]  a_be;
    logic        a_rd, a_wr, a_ready, a_busy, a_err;
    logic [31:0] b_adr, b_wd, b_rdata;
    logic [3:0]  b_be;
    logic        b_rd, b_wr, b_ready, b_busy, b_err;

    data_mem_stall #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(WA)) u_a (
        .clk(clk), .rst(rst), .adr(a_adr), .write_data(a_wd), .byte_en(a_be),
        .mem_read(a_rd), .mem_write(a_wr), .read_data(a_rdata),
        .ready(a_ready), .busy(a_busy), .err(a_err)
    );

    data_mem_stall #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(WB)) u_b (
        .clk(clk), .rst(rst), .adr(b_adr), .write_data(b_wd), .byte_en(b_be),
        .mem_read(b_rd), .mem_write(b_wr), .read_data(b_rdata),
        .ready(b_ready), .busy(b_busy), .err(b_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          e;
        bit          cd;
        logic [31:0] d;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ma, mb;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", n, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_ready || a_err) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: ready=%b err=%b expected no pulse (cyc %0d)",
                         a_ready, a_err, cyc);
            end else begin
                ma = qa.pop_front();
                chk("a_err", 32'(a_err), 32'(ma.e));
                chk("a_ready", 32'(a_ready), 32'(!ma.e));
                chk("a_cycle", 32'(cyc), 32'(ma.at));
                if (ma.cd) chk("a_rdata", a_rdata, ma.d);
            end
        end
    end

    always @(negedge clk) begin
        if (b_ready || b_err) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: ready=%b err=%b expected no pulse (cyc %0d)",
                         b_ready, b_err, cyc);
            end else begin
                mb = qb.pop_front();
                chk("b_err", 32'(b_err), 32'(mb.e));
                chk("b_ready", 32'(b_ready), 32'(!mb.e));
                chk("b_cycle", 32'(cyc), 32'(mb.at));
                if (mb.cd) chk("b_rdata", b_rdata, mb.d);
            end
        end
    end

    task automatic push_a(input bit e, input bit cd, input logic [31:0] d, input int at);
        exp_t x;
        x.e = e; x.cd = cd; x.d = d; x.at = at;
        qa.push_back(x);
    endtask

    task automatic push_b(input bit e, input bit cd, input logic [31:0] d, input int at);
        exp_t x;
        x.e = e; x.cd = cd; x.d = d; x.at = at;
        qb.push_back(x);
    endtask

    // Called just after a posedge; returns just after the capture edge.
    task automatic a_req(input bit rd, input bit wr, input logic [31:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        a_rd = rd; a_wr = wr; a_adr = ad; a_wd = d; a_be = be;
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic a_gap();
        repeat (WA + 1) @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [31:0] ad, input logic [31:0] d,
                           input logic [3:0] be, input bit e);
        push_a(e, e, 32'h0, cyc + 1 + WA);
        a_req(1'b0, 1'b1, ad, d, be);
        a_gap();
    endtask

    task automatic a_read(input logic [31:0] ad, input logic [31:0] d, input bit e);
        push_a(e, 1'b1, e ? 32'h0 : d, cyc + 1 + WA);
        a_req(1'b1, 1'b0, ad, 32'h0, 4'h0);
        a_gap();
    endtask

    task automatic b_write(input logic [31:0] ad, input logic [31:0] d);
        push_b(1'b0, 1'b0, 32'h0, cyc + 1 + WB);
        b_wr = 1'b1; b_adr = ad; b_wd = d; b_be = 4'hF;
        @(posedge clk); #1;
        b_wr = 1'b0;
        repeat (WB + 1) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * DEPTH + 10 && (a_busy || b_busy); i++) begin
            @(posedge clk); #1;
        end
        chk("idle_timeout", 32'(a_busy || b_busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_busy;

    initial begin
        a_adr = '0; a_wd = '0; a_be = '0; a_rd = 1'b0; a_wr = 1'b0;
        b_adr = '0; b_wd = '0; b_be = '0; b_rd = 1'b0; b_wr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
`ifdef DATA_MEM_CLEAR_EN
        chk("rst_busy", 32'(a_busy), 32'h1);
`else
        chk("rst_busy", 32'(a_busy), 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle();

        // Zero-wait instance: writes, then reads held across the DONE cycle.
        b_write(32'h0, 32'hA5A5_A5A5);
        b_write(32'h4, 32'h5A5A_5A5A);
        push_b(1'b0, 1'b1, 32'hA5A5_A5A5, cyc + 1);
        b_rd = 1'b1; b_adr = 32'h0;
        @(posedge clk); #1;
        push_b(1'b0, 1'b1, 32'h5A5A_5A5A, cyc + 2);
        b_adr = 32'h4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full write with busy profile.
        push_a(1'b0, 1'b0, 32'h0, cyc + 1 + WA);
        a_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); chk("busy_w1", 32'(a_busy), 32'h1);
        @(negedge clk); chk("busy_w2", 32'(a_busy), 32'h1);
        @(negedge clk); chk("busy_done", 32'(a_busy), 32'h0);
        @(posedge clk); #1;

        a_read(32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("rdata_hold", a_rdata, 32'hDEAD_BEEF);

        a_write(32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
        a_read(32'h10, 32'hDEAD_BEAA, 1'b0);

        a_write(32'h0, 32'h1122_3344, 4'hF, 1'b0);
        a_read(32'h13, 32'h0, 1'b1);
        chk("rdata_after_err", a_rdata, 32'h0);

        a_write(32'h40, 32'hCAFE_F00D, 4'hF, 1'b1);
        a_read(32'h0, 32'h1122_3344, 1'b0);

        // Conflicting read+write: err on the next cycle, never busy.
        push_a(1'b1, 1'b1, 32'h0, cyc + 1);
        a_req(1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
        @(negedge clk); chk("busy_both", 32'(a_busy), 32'h0);
        @(posedge clk); #1;

        // Write issued while busy must be dropped.
        push_a(1'b0, 1'b1, 32'hDEAD_BEAA, cyc + 1 + WA);
        a_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        a_req(1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
        repeat (WA) @(posedge clk);
        #1;
        a_read(32'h10, 32'hDEAD_BEAA, 1'b0);

        a_write(32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0);
        a_read(32'h10, 32'hDEAD_BEAA, 1'b0);

        // Reset during WAIT of a write aborts it.
        a_write(32'h20, 32'h0000_0005, 4'hF, 1'b0);
        a_req(1'b0, 1'b1, 32'h20, 32'h0000_0099, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef DATA_MEM_CLEAR_EN
        n_busy = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            n_busy++;
        end
        chk("clear_busy_len", 32'(n_busy), 32'(DEPTH));
        @(posedge clk); #1;
        wait_idle();
        a_read(32'h20, 32'h0, 1'b0);
`else
        @(negedge clk);
        chk("busy_after_rst", 32'(a_busy), 32'h0);
        @(posedge clk); #1;
        a_read(32'h20, 32'h0000_0005, 1'b0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("qa_empty", 32'(qa.size()), 32'h0);
        chk("qb_empty", 32'(qb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
